// File: rtl/slow_clk_pkg.sv
`default_nettype none
// ============================================================================
//  slow_clk_pkg : shared state encoding and 100 MHz board defaults
//  Rev 1.0
// ============================================================================
package slow_clk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    localparam int DEF_CNT_W   = 27;
    localparam int DEF_EXPECT  = 100_000_000;
    localparam int DEF_TOL     = 1_000;
    localparam int DEF_TIMEOUT = 120_000_000;

endpackage : slow_clk_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  sync_edge_det : 2-flop synchroniser plus rising-edge detector
//  Rev 1.0
// ============================================================================
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic s1_o,
    output logic rise_o
);

    logic s0_q;
    logic s1_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s0_q   <= d_i;
            s1_q   <= s0_q;
            prev_q <= s1_q;
        end
    end

    assign s1_o   = s1_q;
    assign rise_o = s1_q & ~prev_q;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/slow_clk_meter.sv
`default_nettype none
// ============================================================================
//  slow_clk_meter : measures period/high time of a slow input, flags
//                   tolerance, lock and loss of the input
//  Rev 1.0
// ============================================================================
module slow_clk_meter
    import slow_clk_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int EXPECT  = DEF_EXPECT,
    parameter int TOL     = DEF_TOL,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             in_tol,
    output logic             locked,
    output logic             lost
);

    localparam logic [CNT_W:0]   C_EXPECT     = (CNT_W+1)'(EXPECT);
    localparam logic [CNT_W:0]   C_TOL        = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] C_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    logic s1;
    logic rise;

    sync_edge_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sig_in),
        .s1_o   (s1),
        .rise_o (rise)
    );

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic             vld_q;
    logic             in_tol_q;
    logic             locked_q;
    logic             lost_q;

    logic [CNT_W:0]   per_d;
    logic [CNT_W:0]   dev_d;
    logic             in_tol_d;
    logic             timeout_d;

    // One extra bit keeps the deviation from wrapping for any period value.
    assign per_d     = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign dev_d     = (per_d >= C_EXPECT) ? (per_d - C_EXPECT) : (C_EXPECT - per_d);
    assign in_tol_d  = (dev_d <= C_TOL);
    assign timeout_d = (cnt_q == C_TIMEOUT_M1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            vld_q    <= 1'b0;
            in_tol_q <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            // The rise cycle already has s1=1, so the high counter restarts at 1.
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= ARMED;
                        cnt_q   <= '0;
                        hcnt_q  <= CNT_W'(1);
                    end
                end
                ARMED, LOCKED: begin
                    if (rise) begin
                        period_q <= per_d[CNT_W-1:0];
                        high_q   <= hcnt_q;
                        vld_q    <= 1'b1;
                        in_tol_q <= in_tol_d;
                        locked_q <= 1'b1;
                        state_q  <= LOCKED;
                        cnt_q    <= '0;
                        hcnt_q   <= CNT_W'(1);
                    end else if (timeout_d) begin
                        state_q  <= LOST;
                        lost_q   <= 1'b1;
                        locked_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (s1) begin
                            hcnt_q <= hcnt_q + CNT_W'(1);
                        end
                    end
                end
                LOST: begin
                    if (rise) begin
                        lost_q  <= 1'b0;
                        state_q <= ARMED;
                        cnt_q   <= '0;
                        hcnt_q  <= CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign period_vld = vld_q;
    assign in_tol     = in_tol_q;
    assign locked     = locked_q;
    assign lost       = lost_q;

endmodule : slow_clk_meter
`default_nettype wire

// File: tb/tb_slow_clk_meter.sv
`default_nettype none
// ============================================================================
//  tb_slow_clk_meter : directed self-checking bench for slow_clk_meter
//  Rev 1.0
// ============================================================================
module tb_slow_clk_meter;
    import slow_clk_pkg::*;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_vld;
    logic             in_tol;
    logic             locked;
    logic             lost;

    int checks   = 0;
    int failures = 0;
    int vld_cnt  = 0;

    slow_clk_meter #(
        .CNT_W   (CNT_W),
        .EXPECT  (20),
        .TOL     (2),
        .TIMEOUT (64)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .period_vld (period_vld),
        .in_tol     (in_tol),
        .locked     (locked),
        .lost       (lost)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (period_vld === 1'b1) vld_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge followed by h high / l low cycles; the measurement for
    // the previous interval shows up three ticks after sig_in goes high.
    task automatic rise_step(input int h, input int l, input logic exp_vld,
                             input int exp_per, input int exp_high, input logic exp_tol);
        sig_in = 1'b1;
        tick(2);
        chk("vld_early", 32'(period_vld), 32'(0));
        tick(1);
        chk("vld", 32'(period_vld), 32'(exp_vld));
        if (exp_vld) begin
            chk("period", 32'(period), 32'(exp_per));
            chk("high_time", 32'(high_time), 32'(exp_high));
            chk("in_tol", 32'(in_tol), 32'(exp_tol));
            chk("locked", 32'(locked), 32'(1));
        end
        tick(1);
        chk("vld_one_cycle", 32'(period_vld), 32'(0));
        tick(h - 4);
        sig_in = 1'b0;
        tick(l);
    endtask

    initial begin
        rst    = 1'b0;
        sig_in = 1'b0;
        tick(3);
        chk("rst_period", 32'(period), 32'(0));
        chk("rst_high", 32'(high_time), 32'(0));
        chk("rst_vld", 32'(period_vld), 32'(0));
        chk("rst_locked", 32'(locked), 32'(0));
        chk("rst_lost", 32'(lost), 32'(0));
        rst = 1'b1;

        // Idle with no input never times out
        tick(100);
        chk("idle_state", 32'(u_dut.state_q), 32'(IDLE));
        chk("idle_lost", 32'(lost), 32'(0));
        chk("idle_locked", 32'(locked), 32'(0));
        chk("idle_vld_cnt", 32'(vld_cnt), 32'(0));

        // First rise only arms
        rise_step(10, 10, 1'b0, 0, 0, 1'b0);
        chk("armed_state", 32'(u_dut.state_q), 32'(ARMED));
        chk("armed_locked", 32'(locked), 32'(0));

        rise_step(12, 11, 1'b1, 20, 10, 1'b1);
        rise_step(9, 9, 1'b1, 23, 12, 1'b0);
        rise_step(10, 56, 1'b1, 18, 9, 1'b1);

        // Loss: 64 cycles after the last measurement edge
        chk("pre_lost", 32'(lost), 32'(0));
        chk("pre_lost_locked", 32'(locked), 32'(1));
        tick(1);
        chk("lost", 32'(lost), 32'(1));
        chk("lost_locked", 32'(locked), 32'(0));
        chk("lost_period", 32'(period), 32'(18));
        chk("lost_in_tol", 32'(in_tol), 32'(1));
        tick(20);
        chk("lost_sticky", 32'(lost), 32'(1));
        chk("lost_state", 32'(u_dut.state_q), 32'(LOST));
        chk("lost_vld_cnt", 32'(vld_cnt), 32'(3));

        // Recovery rise clears lost without a measurement
        sig_in = 1'b1;
        tick(2);
        chk("recov_lost_hold", 32'(lost), 32'(1));
        tick(1);
        chk("recov_lost_clr", 32'(lost), 32'(0));
        chk("recov_vld", 32'(period_vld), 32'(0));
        chk("recov_locked", 32'(locked), 32'(0));
        tick(7);
        sig_in = 1'b0;
        tick(10);

        rise_step(10, 10, 1'b1, 20, 10, 1'b1);
        rise_step(10, 54, 1'b1, 20, 10, 1'b1);
        // Rise coincides with cnt == TIMEOUT-1
        rise_step(10, 10, 1'b1, 64, 10, 1'b0);
        chk("edge_to_lost", 32'(lost), 32'(0));
        chk("edge_to_locked", 32'(locked), 32'(1));

        // Async reset mid-period while locked
        tick(5);
        rst = 1'b0;
        #1;
        chk("mid_rst_period", 32'(period), 32'(0));
        chk("mid_rst_high", 32'(high_time), 32'(0));
        chk("mid_rst_in_tol", 32'(in_tol), 32'(0));
        chk("mid_rst_locked", 32'(locked), 32'(0));
        chk("mid_rst_lost", 32'(lost), 32'(0));
        tick(5);
        rst = 1'b1;
        tick(5);
        chk("post_rst_state", 32'(u_dut.state_q), 32'(IDLE));

        rise_step(10, 10, 1'b0, 0, 0, 1'b0);
        chk("post_rst_locked", 32'(locked), 32'(0));
        rise_step(10, 10, 1'b1, 20, 10, 1'b1);
        chk("total_vld_cnt", 32'(vld_cnt), 32'(7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_slow_clk_meter
`default_nettype wire
